// File: rtl/lgv8_pkg.sv
// Shared LEGv8 fetch definitions: PC-function encodings, fetch FSM states, instruction width.
package lgv8_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned PS_W   = 2;

  typedef enum logic [PS_W-1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_LOAD = 2'b10,
    PS_REL  = 2'b11
  } ps_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_e;

  // True for PC functions that load a computed target rather than step or hold.
  function automatic logic is_pc_load(input ps_e ps);
    return (ps == PS_LOAD) || (ps == PS_REL);
  endfunction

endpackage

// File: rtl/ifetch_pc_unit_pc_next_logic.sv
// Combinational next-PC selection from PS, pc_in and ir_pc; shared with future pipelined fetch.
module pc_next_logic
  import lgv8_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  ps_e               ps_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] ir_pc_i,
  input  logic [ADDR_W-1:0] pc_in_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  // Relative branches are taken from the address of the instruction in IR, word-scaled.
  always_comb begin
    next_pc_o = pc_i;
    unique case (ps_i)
      PS_HOLD: next_pc_o = pc_i;
      PS_INC:  next_pc_o = pc_i + ADDR_W'(4);
      PS_LOAD: next_pc_o = pc_in_i;
      PS_REL:  next_pc_o = ir_pc_i + (pc_in_i << 2);
    endcase
  end

endmodule

// File: rtl/ifetch_pc_unit.sv
// LEGv8 multi-cycle fetch stage: PC, IR and instruction-memory read handshake.
// Optional PC_ALIGN_CHECK_EN adds a sticky align_fault and forces loaded targets word-aligned.
module ifetch_pc_unit
  import lgv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned ADDR_W   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        PS,
  input  logic              PCsel,
  input  logic              IL,
  input  logic [63:0]       constant,
  input  logic [63:0]       reg_a,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] ir_pc,
`ifdef PC_ALIGN_CHECK_EN
  output logic              align_fault,
`endif
  output logic              stall
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ir_pc_q;
  logic [INSN_W-1:0]   ir_q;
  logic [ADDR_W-1:0]   pc_in;
  logic [ADDR_W-1:0]   pc_nxt;
  logic                stall_c;
  logic                ir_load_c;
  ps_e                 ps;

  assign ps    = ps_e'(PS);
  assign pc_in = PCsel ? ADDR_W'(constant) : ADDR_W'(reg_a);

  pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
    .ps_i      (ps),
    .pc_i      (pc_q),
    .ir_pc_i   (ir_pc_q),
    .pc_in_i   (pc_in),
    .next_pc_o (pc_nxt)
  );

  // Fetch handshake: stall covers the IL cycle and every S_REQ cycle without imem_ready.
  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    ir_load_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (IL) begin
          stall_c = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ready) begin
          ir_load_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    pc_d    = pc_nxt;
    fault_d = fault_q;
    if (is_pc_load(ps)) begin
      pc_d[1:0] = 2'b00;
      if (!stall_c && (pc_nxt[1:0] != 2'b00)) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign align_fault = fault_q;
`else
  assign pc_d = pc_nxt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_pc_q <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!stall_c) pc_q <= pc_d;
      // ir_pc captures the PC the instruction was fetched from, before this edge's update.
      if (ir_load_c) begin
        ir_q    <= imem_rdata;
        ir_pc_q <= pc_q;
      end
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir_pc       = ir_pc_q;
  assign instruction = ir_q;
  assign pc_plus4    = ir_pc_q + ADDR_W'(4);
  assign stall       = stall_c;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Bench for ifetch_pc_unit: vector table through a scoreboard queue, plus reset and alignment sequences.
module tb_ifetch_pc_unit;

  logic        clock;
  logic        reset;
  logic [1:0]  PS;
  logic        PCsel;
  logic        IL;
  logic [63:0] constant;
  logic [63:0] reg_a;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic [63:0] ir_pc;
  logic        stall;
`ifdef PC_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  ifetch_pc_unit #(.RESET_PC(64'h100), .ADDR_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .PS          (PS),
    .PCsel       (PCsel),
    .IL          (IL),
    .constant    (constant),
    .reg_a       (reg_a),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ir_pc       (ir_pc),
`ifdef PC_ALIGN_CHECK_EN
    .align_fault (align_fault),
`endif
    .stall       (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        il;
    logic [1:0]  ps;
    logic        pcsel;
    logic [63:0] cnst;
    logic [63:0] rega;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic [63:0] e_irpc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic il, input logic [1:0] ps, input logic pcsel,
                              input logic [63:0] cnst, input logic [63:0] rega,
                              input logic rdy, input logic [31:0] rdata,
                              input logic e_stall, input logic e_req, input logic [63:0] e_pc,
                              input logic [31:0] e_ins, input logic [63:0] e_irpc);
    vec_t v;
    v.il = il; v.ps = ps; v.pcsel = pcsel; v.cnst = cnst; v.rega = rega;
    v.rdy = rdy; v.rdata = rdata; v.e_stall = e_stall; v.e_req = e_req;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_irpc = e_irpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one vector at the falling edge, checks stall before the rising edge and state after it.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    logic stall_s;
    IL = v.il; PS = v.ps; PCsel = v.pcsel; constant = v.cnst; reg_a = v.rega;
    imem_ready = v.rdy; imem_rdata = v.rdata;
    exp_q.push_back(v);
    #1 stall_s = stall;
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d stall", idx), 64'(stall_s), 64'(e.e_stall));
    chk($sformatf("v%0d imem_req", idx), 64'(imem_req), 64'(e.e_req));
    chk($sformatf("v%0d pc", idx), pc, e.e_pc);
    chk($sformatf("v%0d imem_addr", idx), imem_addr, e.e_pc);
    chk($sformatf("v%0d instruction", idx), 64'(instruction), 64'(e.e_ins));
    chk($sformatf("v%0d ir_pc", idx), ir_pc, e.e_irpc);
    chk($sformatf("v%0d pc_plus4", idx), pc_plus4, e.e_irpc + 64'd4);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; IL = 1'b0; PS = 2'b00; PCsel = 1'b0; constant = '0; reg_a = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    // Reset held: values at RESET_PC, fetch idle.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst pc", pc, 64'h100);
    chk("rst ir_pc", ir_pc, 64'h100);
    chk("rst instruction", 64'(instruction), 64'h0);
    chk("rst stall", 64'(stall), 64'h0);
    chk("rst imem_req", 64'(imem_req), 64'h0);
`ifdef PC_ALIGN_CHECK_EN
    chk("rst align_fault", 64'(align_fault), 64'h0);
`endif
    reset = 1'b1;

    //           il ps    sel cnst                   rega      rdy rdata          stl req pc                     ins            irpc
    vecs.push_back(mk(0, 2'd0, 0, 64'h0,               64'h0,    0, 32'h0,          0, 0, 64'h100,              32'h0,         64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h100,              32'h0,         64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    1, 32'h8B020020,   0, 0, 64'h104,              32'h8B020020,  64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h104,              32'h8B020020,  64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h104,              32'h8B020020,  64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h104,              32'h8B020020,  64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h104,              32'h8B020020,  64'h100));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    1, 32'hD61F0000,   0, 0, 64'h108,              32'hD61F0000,  64'h104));
    vecs.push_back(mk(0, 2'd2, 1, 64'h200,             64'h0,    0, 32'h0,          0, 0, 64'h200,              32'hD61F0000,  64'h104));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    1, 32'h55555555,   1, 1, 64'h200,              32'hD61F0000,  64'h104));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    1, 32'hAAAA0001,   0, 0, 64'h204,              32'hAAAA0001,  64'h200));
    vecs.push_back(mk(0, 2'd3, 1, 64'hFFFFFFFFFFFFFFFE,64'h0,    0, 32'h0,          0, 0, 64'h1F8,              32'hAAAA0001,  64'h200));
    vecs.push_back(mk(0, 2'd0, 0, 64'h0,               64'h0,    0, 32'h0,          0, 0, 64'h1F8,              32'hAAAA0001,  64'h200));
    vecs.push_back(mk(0, 2'd2, 0, 64'h0,               64'h4000, 0, 32'h0,          0, 0, 64'h4000,             32'hAAAA0001,  64'h200));
    vecs.push_back(mk(0, 2'd2, 1, 64'h300,             64'h0,    0, 32'h0,          0, 0, 64'h300,              32'hAAAA0001,  64'h200));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h300,              32'hAAAA0001,  64'h200));
    vecs.push_back(mk(1, 2'd2, 0, 64'h0,               64'h4000, 1, 32'h94000010,   0, 0, 64'h4000,             32'h94000010,  64'h300));
    vecs.push_back(mk(0, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          0, 0, 64'h4004,             32'h94000010,  64'h300));
    vecs.push_back(mk(1, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h4004,             32'h94000010,  64'h300));
    vecs.push_back(mk(0, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          1, 1, 64'h4004,             32'h94000010,  64'h300));
    vecs.push_back(mk(0, 2'd1, 0, 64'h0,               64'h0,    1, 32'h12345678,   0, 0, 64'h4008,             32'h12345678,  64'h4004));
    vecs.push_back(mk(0, 2'd2, 1, 64'hFFFFFFFFFFFFFFFC,64'h0,    0, 32'h0,          0, 0, 64'hFFFFFFFFFFFFFFFC, 32'h12345678,  64'h4004));
    vecs.push_back(mk(0, 2'd1, 0, 64'h0,               64'h0,    0, 32'h0,          0, 0, 64'h0,                32'h12345678,  64'h4004));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

`ifdef PC_ALIGN_CHECK_EN
    chk("align_fault clear after aligned loads", 64'(align_fault), 64'h0);
`endif

    // Async reset while a request is outstanding.
    IL = 1'b1; PS = 2'b01; imem_ready = 1'b0;
    @(posedge clock); #1;
    chk("midfetch imem_req before reset", 64'(imem_req), 64'h1);
    @(negedge clock);
    IL = 1'b0; PS = 2'b00; reset = 1'b0;
    #1;
    chk("midfetch imem_req dropped", 64'(imem_req), 64'h0);
    chk("midfetch stall", 64'(stall), 64'h0);
    chk("midfetch pc", pc, 64'h100);
    chk("midfetch instruction", 64'(instruction), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'hFFFFFFFF;
    @(posedge clock); #1;
    chk("late ready instruction", 64'(instruction), 64'h0);
    chk("late ready imem_req", 64'(imem_req), 64'h0);
    chk("late ready pc", pc, 64'h100);
    @(negedge clock);
    imem_ready = 1'b0;

`ifdef PC_ALIGN_CHECK_EN
    PS = 2'b10; PCsel = 1'b0; reg_a = 64'h4002;
    @(posedge clock); #1;
    chk("align pc forced", pc, 64'h4000);
    chk("align_fault set", 64'(align_fault), 64'h1);
    @(negedge clock);
    PS = 2'b01;
    @(posedge clock); #1;
    chk("align pc after inc", pc, 64'h4004);
    chk("align_fault sticky", 64'(align_fault), 64'h1);
    @(negedge clock);
    PS = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_pc_unit.md
Name: ifetch_pc_unit

Overview:
- Upstream fetch stage for the multi-cycle LEGv8 core. Owns the program counter (PC), the instruction register (IR) and the instruction-memory read handshake.
- Feeds `instruction` to the control unit.
- Consumes the control unit's PS, PCsel and IL fields, its `constant`, and register-file bus A.
- Raises `stall` so the control unit's state register holds while a fetch is outstanding.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- ADDR_W, 64, PC / instruction-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- PS  in  2  PC function: 00 hold, 01 PC+4, 10 load pc_in, 11 relative branch.
- PCsel  in  1  pc_in source: 1 = constant, 0 = reg_a.
- IL  in  1  instruction-load request from the control word.
- constant  in  64  control-unit constant (sign-extended branch offset or absolute).
- reg_a  in  64  register-file bus A (BR/BLR/RET target).
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  read address; equals `pc`.
- imem_rdata  in  32  read data; valid when `imem_ready`=1.
- imem_ready  in  1  read-complete strobe.
- instruction  out  32  instruction register.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  `ir_pc`+4, the link value for BL.
- ir_pc  out  ADDR_W  address of the instruction currently in IR.
- stall  out  1  fetch in progress; the control unit holds state and control word.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, instruction=32'h0, ir_pc=RESET_PC.
  - State=S_IDLE, imem_req=0, stall=0.
  - Reset mid-fetch abandons the request. Any late imem_ready is ignored, because it arrives in S_IDLE with IL=0 or is a new fetch.
- pc_in = PCsel ? constant : reg_a.
- FSM, two states:
  - S_IDLE:
    - imem_req=0.
    - IL=1: stall=1 (combinational), next S_REQ; PC, IR and ir_pc unchanged.
    - IL=0: stall=0, PC updated per PS.
  - S_REQ:
    - imem_req=1; imem_addr=pc, held stable for the whole request.
    - imem_ready=0: stall=1, stay.
    - imem_ready=1: stall=0; IR<=imem_rdata; ir_pc<=pc; PC updated per PS; next S_IDLE.
- PC update, applied only in cycles with stall=0:
  - 00: pc unchanged.
  - 01: pc+4.
  - 10: pc_in.
  - 11: ir_pc + (pc_in<<2). This uses ir_pc as it was before the same-edge IR load.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- PS is ignored while stall=1. The control word is frozen during a stall, so PS=01 in the IF word takes effect exactly once, on the completing edge.
- Minimum fetch latency: 2 cycles (IL cycle plus one S_REQ cycle with imem_ready=1). Each extra wait cycle adds 1.
- IL=0 while in S_REQ (not legal from the control unit): the request still completes, IR loads, and the FSM returns to S_IDLE.
- imem_ready in S_IDLE is ignored.
- pc_plus4 = ir_pc+4, combinational.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output `align_fault` (1 bit, reset 0).
  - Set sticky on any stall=0 PC load (PS=10/11) whose target has bits [1:0]≠00.
  - The loaded PC has bits [1:0] forced to 00.
  - Cleared only by reset.
- Undefined: port absent; the target is loaded unmodified.

Decomposition:
- Shared package lgv8_pkg:
  - PS encodings: PS_HOLD, PS_INC, PS_LOAD, PS_REL.
  - FSM state constants: S_IDLE, S_REQ.
  - INSN_W=32.
- Sub-module pc_next_logic: purely combinational PS/pc_in/ir_pc → next-PC selection, reusable by a future pipelined fetch.
- The FSM, IR and registers stay in the top.

Test Plan:
- Reset: hold reset=0 with RESET_PC=64'h100 → pc=0x100, instruction=0, stall=0, imem_req=0. Release and check the values hold.
- Zero-wait fetch:
  - Stimulus: IL=1, PS=01, imem_ready=1 on the first S_REQ cycle, imem_rdata=32'h8B020020.
  - Response: stall high for exactly 1 cycle; then instruction=8B020020, ir_pc=0x100, pc=0x104.
- Wait states: imem_ready delayed 3 cycles → stall=1 for 4 cycles, imem_addr constant at 0x104, PC unchanged until the completing edge.
- Relative branch: ir_pc=0x200, PS=11, PCsel=1, constant=64'hFFFFFFFFFFFFFFFE (−2), IL=0 → pc=0x1F8 next edge; stall stays 0.
- BR and BL link: PS=10, PCsel=0, reg_a=0x4000 → pc=0x4000; with ir_pc=0x300, pc_plus4=0x304.
- Async reset mid-fetch: reset=0 in S_REQ with imem_ready=0 → imem_req drops immediately; a later imem_ready pulse with IL=0 leaves instruction=0.
- With PC_ALIGN_CHECK_EN defined, additionally: PS=10 with reg_a=0x4002 → pc=0x4000, align_fault=1 and stays 1.
